// File: rtl/vga_sync_receiver.sv
// Sink-side VGA timing recovery: rebuilds pixel coordinates from sync edges, locks
// onto the expected frame timing, counts sync errors and checksums each locked frame.
module vga_sync_receiver #(
  parameter int H_DISPLAY    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_TOTAL      = 800,
  parameter int V_DISPLAY    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [5:0]  rgb_in,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_start,
  output logic [15:0] checksum,
  output logic        checksum_valid,
  output logic [7:0]  err_count
);

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SS      = 10'(H_SYNC_START);
  localparam logic [9:0] V_SS      = 10'(V_SYNC_START);
  localparam logic [9:0] H_DISP    = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP    = 10'(V_DISPLAY);
  localparam logic [9:0] H_LASTPIX = 10'(H_DISPLAY - 1);
  localparam logic [9:0] V_LASTPIX = 10'(V_DISPLAY - 1);
  localparam logic [3:0] GOOD_LAST = 4'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  logic        hs_q, hs_d, vs_q, vs_d, hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [5:0]  rgb_q, rgb_d, rgb_s2_q, rgb_s2_d;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  state_t      state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic [7:0]  err_q, err_d;
  logic        locked_q, locked_d, pix_valid_q, pix_valid_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [5:0]  pix_rgb_q, pix_rgb_d;
  logic        frame_start_q, frame_start_d, frame_ok_q, frame_ok_d;
  logic [15:0] acc_q, acc_d, checksum_q, checksum_d;
  logic        checksum_valid_q, checksum_valid_d;

  logic       hs_edge, vs_edge, h_wrap, h_exp, v_exp, sync_err, st_locked;
  logic [9:0] h_free, v_free;

  // Counters hold the position of the sample one stage behind the input
  // registers; prediction compares the free-running count against observed edges.
  always_comb begin
    hs_d      = hsync_in;
    vs_d      = vsync_in;
    rgb_d     = rgb_in;
    hs_prev_d = hs_q;
    vs_prev_d = vs_q;
    rgb_s2_d  = rgb_q;

    hs_edge  = hs_q & ~hs_prev_q;
    vs_edge  = vs_q & ~vs_prev_q;
    h_wrap   = (h_cnt_q == H_LAST);
    h_free   = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_free   = h_wrap ? ((v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1) : v_cnt_q;
    h_exp    = (h_free == H_SS);
    v_exp    = h_wrap && (v_free == V_SS);
    sync_err = (hs_edge ^ h_exp) | (vs_edge ^ v_exp);

    h_cnt_d = h_free;
    v_cnt_d = v_free;
    state_d = state_q;
    good_d  = good_q;
    err_d   = err_q;

    case (state_q)
      SEARCH: begin
        if (hs_edge) h_cnt_d = H_SS;
        // vsync rises at the start of a line, so the horizontal position is 0
        if (vs_edge) begin
          state_d = ACQUIRE;
          h_cnt_d = 10'd0;
          v_cnt_d = V_SS;
          good_d  = 4'd0;
        end
      end
      ACQUIRE: begin
        if (hs_edge) h_cnt_d = H_SS;
        if (vs_edge) v_cnt_d = V_SS;
        if (sync_err) begin
          state_d = SEARCH;
          good_d  = 4'd0;
        end else if (vs_edge) begin
          good_d = good_q + 4'd1;
          if (good_q == GOOD_LAST) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (sync_err) begin
          state_d = SEARCH;
          err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
        end
      end
      default: state_d = SEARCH;
    endcase

    st_locked     = (state_q == LOCKED);
    locked_d      = st_locked;
    pix_valid_d   = st_locked && (h_cnt_q < H_DISP) && (v_cnt_q < V_DISP);
    pix_x_d       = pix_valid_d ? h_cnt_q : 10'd0;
    pix_y_d       = pix_valid_d ? v_cnt_q : 10'd0;
    pix_rgb_d     = pix_valid_d ? rgb_s2_q : 6'd0;
    frame_start_d = st_locked && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

    acc_d = acc_q;
    if (frame_start_d)    acc_d = {10'd0, rgb_s2_q};
    else if (pix_valid_d) acc_d = acc_q + {10'd0, rgb_s2_q};

    frame_ok_d = frame_ok_q;
    if (frame_start_d)   frame_ok_d = 1'b1;
    else if (!st_locked) frame_ok_d = 1'b0;

    // The accumulator includes the last pixel one cycle after it is emitted
    checksum_d       = checksum_q;
    checksum_valid_d = 1'b0;
    if (pix_valid_q && pix_x_q == H_LASTPIX && pix_y_q == V_LASTPIX && frame_ok_q) begin
      checksum_d       = acc_q;
      checksum_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q             <= 1'b0;
      vs_q             <= 1'b0;
      hs_prev_q        <= 1'b0;
      vs_prev_q        <= 1'b0;
      rgb_q            <= 6'd0;
      rgb_s2_q         <= 6'd0;
      h_cnt_q          <= 10'd0;
      v_cnt_q          <= 10'd0;
      state_q          <= SEARCH;
      good_q           <= 4'd0;
      err_q            <= 8'd0;
      locked_q         <= 1'b0;
      pix_valid_q      <= 1'b0;
      pix_x_q          <= 10'd0;
      pix_y_q          <= 10'd0;
      pix_rgb_q        <= 6'd0;
      frame_start_q    <= 1'b0;
      frame_ok_q       <= 1'b0;
      acc_q            <= 16'd0;
      checksum_q       <= 16'd0;
      checksum_valid_q <= 1'b0;
    end else begin
      hs_q             <= hs_d;
      vs_q             <= vs_d;
      hs_prev_q        <= hs_prev_d;
      vs_prev_q        <= vs_prev_d;
      rgb_q            <= rgb_d;
      rgb_s2_q         <= rgb_s2_d;
      h_cnt_q          <= h_cnt_d;
      v_cnt_q          <= v_cnt_d;
      state_q          <= state_d;
      good_q           <= good_d;
      err_q            <= err_d;
      locked_q         <= locked_d;
      pix_valid_q      <= pix_valid_d;
      pix_x_q          <= pix_x_d;
      pix_y_q          <= pix_y_d;
      pix_rgb_q        <= pix_rgb_d;
      frame_start_q    <= frame_start_d;
      frame_ok_q       <= frame_ok_d;
      acc_q            <= acc_d;
      checksum_q       <= checksum_d;
      checksum_valid_q <= checksum_valid_d;
    end
  end

  assign locked         = locked_q;
  assign pix_valid      = pix_valid_q;
  assign pix_x          = pix_x_q;
  assign pix_y          = pix_y_q;
  assign pix_rgb        = pix_rgb_q;
  assign frame_start    = frame_start_q;
  assign checksum       = checksum_q;
  assign checksum_valid = checksum_valid_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver using a scaled-down timing (48x35 total, 40x30 active)
// so whole frames fit in a short run; a behavioural generator drives the inputs.
module tb_vga_sync_receiver;
  localparam int HD = 40, HSS = 42, HSE = 45, HT = 48;
  localparam int VD = 30, VSS = 31, VSE = 33, VT = 35;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0, reset = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [5:0]  rgb_in = 6'd0;
  logic        locked, pix_valid, frame_start, checksum_valid;
  logic [9:0]  pix_x, pix_y;
  logic [5:0]  pix_rgb;
  logic [15:0] checksum;
  logic [7:0]  err_count;

  vga_sync_receiver #(
    .H_DISPLAY(HD), .H_SYNC_START(HSS), .H_TOTAL(HT),
    .V_DISPLAY(VD), .V_SYNC_START(VSS), .V_TOTAL(VT), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
    .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .checksum(checksum), .checksum_valid(checksum_valid),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          hpos_mode;
    logic [5:0]  rgb;
    logic [15:0] exp_sum;
    int          exp_pv;
  } vec_t;
  vec_t vecs[4];

  int checks = 0, failures = 0, cyc = 0;
  int gen_h = 0, gen_v = 0, gen_ht = HT, supp_line = -1, supp_cyc = 0;
  bit rgb_hpos = 1'b0;
  logic [5:0] rgb_const = 6'd0;
  int hist_h[3], hist_v[3];
  logic [5:0] hist_rgb[3];
  bit hist_disp[3];
  int mon_err = 0, pv_count = 0, frame_pv = 0, cv_count = 0, last_cv_cyc = 0, cv_interval = 0;
  int vs_rise_count = 0, vs_rise_cyc = 0, lock_rise_cyc = 0, lock_fall_cyc = 0;
  bit locked_prev = 1'b0, ever_locked = 1'b0, ever_pv = 1'b0, ever_err = 1'b0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    logic hs, vs;
    hs = (gen_h >= HSS && gen_h < HSE) && (gen_v != supp_line);
    vs = (gen_v >= VSS && gen_v < VSE);
    if (gen_v == supp_line && gen_h == HSS) supp_cyc = cyc;
    if (vs && !vsync_in) begin
      vs_rise_count++;
      vs_rise_cyc = cyc;
    end
    hsync_in = hs;
    vsync_in = vs;
    rgb_in   = rgb_hpos ? 6'(gen_h) : rgb_const;
    for (int i = 2; i > 0; i--) begin
      hist_h[i] = hist_h[i-1]; hist_v[i] = hist_v[i-1];
      hist_rgb[i] = hist_rgb[i-1]; hist_disp[i] = hist_disp[i-1];
    end
    hist_h[0] = gen_h; hist_v[0] = gen_v; hist_rgb[0] = rgb_in;
    hist_disp[0] = (gen_h < HD) && (gen_v < VD);
  endtask

  // Outputs observed 1 time unit after each edge reflect the sample driven three ticks earlier
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pix_valid) begin
      if (int'(pix_x) != hist_h[2] || int'(pix_y) != hist_v[2] || pix_rgb != hist_rgb[2]) mon_err++;
    end else if (pix_x != 10'd0 || pix_y != 10'd0 || pix_rgb != 6'd0) mon_err++;
    if (pix_valid != (locked && hist_disp[2])) mon_err++;
    if (frame_start != (locked && hist_h[2] == 0 && hist_v[2] == 0)) mon_err++;
    if (frame_start) pv_count = 0;
    if (pix_valid) pv_count++;
    if (checksum_valid) begin
      cv_count++;
      frame_pv    = pv_count;
      cv_interval = cyc - last_cv_cyc;
      last_cv_cyc = cyc;
    end
    if (locked && !locked_prev) lock_rise_cyc = cyc;
    if (!locked && locked_prev) lock_fall_cyc = cyc;
    locked_prev = locked;
    if (locked) ever_locked = 1'b1;
    if (pix_valid) ever_pv = 1'b1;
    if (err_count != 8'd0) ever_err = 1'b1;
    if (gen_v == supp_line && gen_h == gen_ht - 1) supp_line = -1;
    gen_h++;
    if (gen_h >= gen_ht) begin
      gen_h = 0;
      gen_v = (gen_v == VT - 1) ? 0 : gen_v + 1;
    end
    applyStimulus();
  endtask

  task automatic wait_cv(input int budget, output bit ok);
    int start;
    start = cv_count;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (cv_count != start) ok = 1'b1;
    end
  endtask

  task automatic wait_locked(input bit want, input int budget, output bit ok);
    ok = (locked == want);
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (locked == want) ok = 1'b1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_locked"}, locked, 0);
    checkOutput({tag, "_pix_valid"}, pix_valid, 0);
    checkOutput({tag, "_pix_xy"}, {pix_x, pix_y}, 0);
    checkOutput({tag, "_pix_rgb"}, pix_rgb, 0);
    checkOutput({tag, "_frame_start"}, frame_start, 0);
    checkOutput({tag, "_checksum"}, checksum, 0);
    checkOutput({tag, "_checksum_valid"}, checksum_valid, 0);
    checkOutput({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int cv_before;
    for (int i = 0; i < 3; i++) begin
      hist_h[i] = 0; hist_v[i] = 0; hist_rgb[i] = 6'd0; hist_disp[i] = 1'b0;
    end
    // Sums over 40x30 active pixels: 1200*63 wraps to 0x2750, x summed per line is 780
    vecs[0] = '{1'b0, 6'h3F, 16'h2750, 1200};
    vecs[1] = '{1'b0, 6'h01, 16'h04B0, 1200};
    vecs[2] = '{1'b0, 6'h00, 16'h0000, 1200};
    vecs[3] = '{1'b1, 6'h00, 16'h5B68, 1200};

    #1 reset = 1'b1;
    #2 check_all_zero("reset_async");
    applyStimulus();
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    vs_rise_count = 0;
    rgb_const = 6'h3F;

    wait_locked(1'b1, 4 * FRAME, ok);
    checkOutput("initial_lock", ok, 1);
    checkOutput("vsync_edges_to_lock", vs_rise_count, 3);
    checkOutput("lock_latency", lock_rise_cyc - vs_rise_cyc, 3);

    for (int i = 0; i < 4; i++) begin
      rgb_hpos  = vecs[i].hpos_mode;
      rgb_const = vecs[i].rgb;
      wait_cv(2 * FRAME, ok);
      checkOutput($sformatf("vec%0d_cv_seen", i), ok, 1);
      checkOutput($sformatf("vec%0d_checksum", i), checksum, vecs[i].exp_sum);
      checkOutput($sformatf("vec%0d_pix_count", i), frame_pv, vecs[i].exp_pv);
      if (i > 0) checkOutput($sformatf("vec%0d_cv_interval", i), cv_interval, FRAME);
    end
    checkOutput("pixel_tracking_errors", mon_err, 0);
    checkOutput("err_count_clean", err_count, 0);

    // Missing hsync on line 10 of the next frame while locked
    supp_line = 10;
    cv_before = cv_count;
    wait_locked(1'b0, 2 * FRAME, ok);
    checkOutput("lock_lost", ok, 1);
    checkOutput("lock_drop_latency", lock_fall_cyc - supp_cyc, 3);
    checkOutput("err_count_after_drop", err_count, 1);
    checkOutput("checksum_held", checksum, 16'h5B68);
    vs_rise_count = 0;
    wait_locked(1'b1, 4 * FRAME, ok);
    checkOutput("relock", ok, 1);
    checkOutput("relock_vsync_edges", vs_rise_count, 3);
    checkOutput("no_cv_broken_frame", cv_count, cv_before);
    wait_cv(2 * FRAME, ok);
    checkOutput("relock_cv_seen", ok, 1);
    checkOutput("relock_checksum", checksum, 16'h5B68);
    checkOutput("err_count_still_one", err_count, 1);

    // Asynchronous reset in the middle of line 20
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      tick();
      if (gen_v == 20 && gen_h == 10) ok = 1'b1;
    end
    checkOutput("reached_line20", ok, 1);
    checkOutput("locked_before_reset", locked, 1);
    #2 reset = 1'b1;
    #1 check_all_zero("reset_midframe");
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    vs_rise_count = 0;
    wait_locked(1'b1, 4 * FRAME, ok);
    checkOutput("post_reset_lock", ok, 1);
    checkOutput("post_reset_vsync_edges", vs_rise_count, 3);
    checkOutput("post_reset_lock_latency", lock_rise_cyc - vs_rise_cyc, 3);
    checkOutput("post_reset_err_count", err_count, 0);
    wait_cv(2 * FRAME, ok);
    checkOutput("post_reset_checksum", checksum, 16'h5B68);

    // One extra clock per line must keep the receiver out of lock
    reset = 1'b1;
    tick();
    tick();
    gen_ht = HT + 1;
    reset = 1'b0;
    ever_locked = 1'b0;
    ever_pv = 1'b0;
    ever_err = 1'b0;
    for (int i = 0; i < 6 * FRAME; i++) tick();
    checkOutput("bad_timing_never_locked", ever_locked, 0);
    checkOutput("bad_timing_no_pix_valid", ever_pv, 0);
    checkOutput("bad_timing_err_count", ever_err, 0);
    checkOutput("pixel_tracking_errors_final", mon_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
